usb_rst_sequencer: RTL

Avalon-MM slave that sequences the active-low reset line of the USB host controller chip. It replaces direct software bit-banging of the reset pin with a timed assert/settle sequence, a busy/done status and an optional interrupt. It sits on the Nios II system bus next to the USB PIOs. Its output drives the chip reset pin directly.

---
 rtl/usb_rst_sequencer_pkg.sv | 28 ++
 rtl/usb_rst_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/usb_rst_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rst_sequencer_pkg: FSM encoding, register map, bit indices     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package usb_rst_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  localparam logic [1:0] C_ADDR_CONTROL = 2'd0;
  localparam logic [1:0] C_ADDR_STATUS  = 2'd1;
  localparam logic [1:0] C_ADDR_ASSERT  = 2'd2;
  localparam logic [1:0] C_ADDR_SETTLE  = 2'd3;

  localparam int C_CTRL_START    = 0;
  localparam int C_CTRL_FORCE    = 1;
  localparam int C_CTRL_IRQ_EN   = 2;

  localparam int C_STAT_BUSY     = 0;
  localparam int C_STAT_DONE     = 1;
  localparam int C_STAT_STATE_LO = 2;

endpackage
`default_nettype wire

// File: rtl/usb_rst_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | usb_rst_sequencer: Avalon-MM timed assert/settle USB chip reset    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module usb_rst_sequencer
  import usb_rst_sequencer_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int DEF_ASSERT = 500000,
  parameter int DEF_SETTLE = 50000,
  parameter int AUTO_START = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        irq
);

  // Counter load value max(v,1)-1, so a programmed 0 behaves as 1.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_assert_cycles;
  logic [CNT_W-1:0] r_settle_cycles;
  logic             r_force;
  logic             r_irq_en;
  logic             r_done;
  logic             r_usb_rst_n;
  logic             w_done_set;
  logic             w_force_nxt;
  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_unused_writedata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr & (address == C_ADDR_CONTROL);
  assign w_start   = w_wr_ctrl & writedata[C_CTRL_START] & (r_state == ST_IDLE);
  assign w_force_nxt = w_wr_ctrl ? writedata[C_CTRL_FORCE] : r_force;
  assign w_unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= (AUTO_START != 0) ? ST_ASSERT : ST_IDLE;
      r_count <= load_val(CNT_W'(DEF_ASSERT));
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_ASSERT;
          w_count_nxt = load_val(r_assert_cycles);
        end
      end
      ST_ASSERT: begin
        if (r_count == '0) begin
          w_state_nxt = ST_SETTLE;
          w_count_nxt = load_val(r_shadow);
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_count == '0) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin is computed from next-state values so it moves on the same edge as the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_force         <= 1'b0;
      r_irq_en        <= 1'b0;
      r_done          <= 1'b0;
      r_assert_cycles <= CNT_W'(DEF_ASSERT);
      r_settle_cycles <= CNT_W'(DEF_SETTLE);
      r_shadow        <= CNT_W'(DEF_SETTLE);
      r_usb_rst_n     <= 1'b0;
    end else begin
      r_usb_rst_n <= ~((w_state_nxt == ST_ASSERT) | w_force_nxt);
      r_force     <= w_force_nxt;
      if (w_wr_ctrl) begin
        r_irq_en <= writedata[C_CTRL_IRQ_EN];
      end
      if (w_start) begin
        r_shadow <= r_settle_cycles;
      end
      if (w_wr && address == C_ADDR_ASSERT) begin
        r_assert_cycles <= writedata[CNT_W-1:0];
      end
      if (w_wr && address == C_ADDR_SETTLE) begin
        r_settle_cycles <= writedata[CNT_W-1:0];
      end
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_wr && address == C_ADDR_STATUS && writedata[C_STAT_DONE]) begin
        r_done <= 1'b0;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      C_ADDR_CONTROL: begin
        readdata[C_CTRL_FORCE]  = r_force;
        readdata[C_CTRL_IRQ_EN] = r_irq_en;
      end
      C_ADDR_STATUS: begin
        readdata[C_STAT_BUSY]           = (r_state != ST_IDLE);
        readdata[C_STAT_DONE]           = r_done;
        readdata[C_STAT_STATE_LO +: 2]  = r_state;
      end
      C_ADDR_ASSERT: readdata = 32'(r_assert_cycles);
      C_ADDR_SETTLE: readdata = 32'(r_settle_cycles);
      default:       readdata = '0;
    endcase
  end

  assign usb_rst_n = r_usb_rst_n;
  assign irq       = r_done & r_irq_en;

endmodule
`default_nettype wire
